// File: rtl/mem_pkg.sv
// Shared types and constants for the BRAM port arbiter and memory wrapper.
package mem_pkg;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef enum logic {
        READY  = 1'b0,
        WR_GAP = 1'b1
    } arb_state_e;

    localparam int READ_LAT_DEF = 3;
    localparam int STREAK_W     = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and BRAM-side signals of one arbitrated memory port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic [ADDR_W-1:0] if_raddr;

    logic              ls_req;
    logic [3:0]        ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [31:0]       ls_rdata;
    logic [ADDR_W-1:0] ls_raddr;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_raddr,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_raddr,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_raddr,
        output ls_req, ls_we, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_raddr,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout,
        input  busy
    );
endinterface

// File: rtl/mem_rd_tag_pipe.sv
// Fixed-depth shift register of {valid, owner, addr} tags for in-flight reads.
module mem_rd_tag_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH  = READ_LAT_DEF,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  owner_e            in_owner,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output owner_e            out_owner,
    output logic [ADDR_W-1:0] out_addr,
    output logic              any_valid
);

    logic [DEPTH-1:0]  vld_q, vld_d;
    owner_e            own_q  [DEPTH];
    owner_e            own_d  [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];

    always_comb begin
        vld_d[0]  = in_valid;
        own_d[0]  = in_owner;
        addr_d[0] = in_valid ? in_addr : '0;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1];
            own_d[i]  = own_q[i-1];
            addr_d[i] = addr_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                own_q[i]  <= OWN_IF;
                addr_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) begin
                own_q[i]  <= own_d[i];
                addr_q[i] <= addr_d[i];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_owner = own_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];
    assign any_valid = |vld_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF read-only, LS read/write) arbiter for one BRAM port,
// with write-turnaround bubble, LS streak limit and read return routing.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int READ_LAT      = READ_LAT_DEF,
    parameter int MAX_LS_STREAK = 4,
    parameter int ADDR_W        = 32
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    arb_state_e          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;

    logic              if_gnt_c, ls_gnt_c, ls_wr_c;
    logic              rd_valid;
    owner_e            rd_owner;
    logic [ADDR_W-1:0] rd_addr;
    logic              pipe_busy;

    // IF wins contention only once LS has used up its streak allowance
    always_comb begin
        if_gnt_c = 1'b0;
        ls_gnt_c = 1'b0;
        if (rst_n && state_q == READY) begin
            if (bus.ls_req &&
                !(bus.if_req && int'(streak_q) == MAX_LS_STREAK)) begin
                ls_gnt_c = 1'b1;
            end else if (bus.if_req) begin
                if_gnt_c = 1'b1;
            end
        end
    end

    assign ls_wr_c = ls_gnt_c && (bus.ls_we != 4'b0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            READY:  if (ls_wr_c) state_d = WR_GAP;
            WR_GAP: state_d = READY;
            default: state_d = READY;
        endcase
    end

    always_comb begin
        streak_d = streak_q;
        if (!bus.if_req || if_gnt_c) begin
            streak_d = '0;
        end else if (ls_gnt_c && streak_q != '1) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= READY;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        bus.if_gnt   = if_gnt_c;
        bus.ls_gnt   = ls_gnt_c;
        bus.mem_en   = if_gnt_c | ls_gnt_c;
        bus.mem_we   = 4'b0;
        bus.mem_addr = '0;
        bus.mem_din  = 32'b0;
        if (ls_gnt_c) begin
            bus.mem_we   = bus.ls_we;
            bus.mem_addr = bus.ls_addr;
            bus.mem_din  = bus.ls_wdata;
        end else if (if_gnt_c) begin
            bus.mem_addr = bus.if_addr;
        end
    end

    mem_rd_tag_pipe #(
        .DEPTH  (READ_LAT),
        .ADDR_W (ADDR_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (if_gnt_c | (ls_gnt_c & ~ls_wr_c)),
        .in_owner  (ls_gnt_c ? OWN_LS : OWN_IF),
        .in_addr   (ls_gnt_c ? bus.ls_addr : bus.if_addr),
        .out_valid (rd_valid),
        .out_owner (rd_owner),
        .out_addr  (rd_addr),
        .any_valid (pipe_busy)
    );

    always_comb begin
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = 32'b0;
        bus.if_raddr  = '0;
        bus.ls_rvalid = 1'b0;
        bus.ls_rdata  = 32'b0;
        bus.ls_raddr  = '0;
        if (rd_valid && rd_owner == OWN_IF) begin
            bus.if_rvalid = 1'b1;
            bus.if_rdata  = bus.mem_dout;
            bus.if_raddr  = rd_addr;
        end
        if (rd_valid && rd_owner == OWN_LS) begin
            bus.ls_rvalid = 1'b1;
            bus.ls_rdata  = bus.mem_dout;
            bus.ls_raddr  = rd_addr;
        end
    end

    assign bus.busy = pipe_busy | (state_q == WR_GAP);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 3-cycle BRAM model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

    mem_port_arbiter #(
        .READ_LAT      (3),
        .MAX_LS_STREAK (4),
        .ADDR_W        (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // BRAM model: word i preloads to 0x5A000000 | (i*4), except 0x80
    logic [31:0] mem [0:1023];
    logic [31:0] rd0, rd1, rd2;
    bit          mem_init_done = 1'b0;
    logic [9:0]  midx;

    assign midx         = bus.mem_addr[11:2];
    assign bus.mem_dout = rd2;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 1024; i++)
                mem[i] <= (i == 32) ? 32'h11223344 : (32'h5A000000 | 32'(i * 4));
            mem_init_done <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_we != 4'b0) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_we[b]) mem[midx][8*b +: 8] <= bus.mem_din[8*b +: 8];
            end else begin
                rd0 <= mem[midx];
            end
        end
        rd1 <= rd0;
        rd2 <= rd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 4'b0;
        bus.ls_addr  = '0;
        bus.ls_wdata = 32'b0;
    endtask

    // IF grants must never carry write enables
    always @(negedge clk)
        if (bus.if_gnt) chk("if_we0", 32'(bus.mem_we), 32'd0);

    initial begin
        rst_n = 1'b0;
        idle();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        repeat (2) @(posedge clk);
        smp();
        chk("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rvalid", 32'({bus.if_rvalid, bus.ls_rvalid}), 32'd0);
        step();
        rst_n = 1'b1;
        idle();
        step();
        step();

        // single IF read
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        smp();
        chk("if1_gnt", 32'(bus.if_gnt), 32'd1);
        chk("if1_en", 32'(bus.mem_en), 32'd1);
        chk("if1_addr", bus.mem_addr, 32'h100);
        step();
        idle();
        smp();
        chk("if1_busy", 32'(bus.busy), 32'd1);
        chk("if1_idle_rd", bus.if_rdata, 32'd0);
        step();
        step();
        smp();
        chk("if1_rvalid", 32'(bus.if_rvalid), 32'd1);
        chk("if1_raddr", bus.if_raddr, 32'h100);
        chk("if1_rdata", bus.if_rdata, 32'h5A000100);
        step();
        smp();
        chk("if1_rv_off", 32'(bus.if_rvalid), 32'd0);
        repeat (3) step();

        // LS full write, gap, read back
        bus.ls_req   = 1'b1;
        bus.ls_we    = 4'hF;
        bus.ls_addr  = 32'h40;
        bus.ls_wdata = 32'hDEADBEEF;
        smp();
        chk("lsw_gnt", 32'(bus.ls_gnt), 32'd1);
        chk("lsw_we", 32'(bus.mem_we), 32'hF);
        chk("lsw_din", bus.mem_din, 32'hDEADBEEF);
        step();
        bus.ls_we = 4'h0;
        smp();
        chk("gap_gnt", 32'(bus.ls_gnt), 32'd0);
        chk("gap_en", 32'(bus.mem_en), 32'd0);
        chk("gap_busy", 32'(bus.busy), 32'd1);
        step();
        smp();
        chk("lsr_gnt", 32'(bus.ls_gnt), 32'd1);
        step();
        idle();
        step();
        step();
        smp();
        chk("lsr_rvalid", 32'(bus.ls_rvalid), 32'd1);
        chk("lsr_rdata", bus.ls_rdata, 32'hDEADBEEF);
        chk("lsr_raddr", bus.ls_raddr, 32'h40);
        repeat (4) step();

        // contention: 4 LS grants then 1 IF grant, repeating
        for (int c = 0; c < 13; c++) begin
            if (c < 10) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 32'h200 + 32'(4 * (c / 5));
                bus.ls_req  = 1'b1;
                bus.ls_addr = 32'h300 + 32'(4 * (c - c / 5));
            end else begin
                idle();
            end
            smp();
            if (c < 10) begin
                chk("arb_ls_gnt", 32'(bus.ls_gnt), 32'((c % 5) != 4));
                chk("arb_if_gnt", 32'(bus.if_gnt), 32'((c % 5) == 4));
            end
            if (c >= 3) begin
                automatic int g = c - 3;
                automatic logic [31:0] la = 32'h300 + 32'(4 * (g - g / 5));
                if ((g % 5) != 4) begin
                    chk("arb_ls_rv", 32'({bus.ls_rvalid, bus.if_rvalid}), 32'd2);
                    chk("arb_ls_raddr", bus.ls_raddr, la);
                    chk("arb_ls_rdata", bus.ls_rdata, 32'h5A000000 | la);
                end else begin
                    chk("arb_if_rv", 32'({bus.ls_rvalid, bus.if_rvalid}), 32'd1);
                    chk("arb_if_raddr", bus.if_raddr, 32'h200 + 32'(4 * (g / 5)));
                end
            end
            step();
        end
        repeat (3) step();

        // back-to-back IF reads
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 32'(4 * c);
            end else begin
                idle();
            end
            smp();
            if (c < 4) chk("pipe_gnt", 32'(bus.if_gnt), 32'd1);
            if (c >= 3 && c <= 6) begin
                chk("pipe_rv", 32'(bus.if_rvalid), 32'd1);
                chk("pipe_raddr", bus.if_raddr, 32'(4 * (c - 3)));
                chk("pipe_rdata", bus.if_rdata, 32'h5A000000 | 32'(4 * (c - 3)));
            end
            if (c == 7) chk("pipe_rv_off", 32'(bus.if_rvalid), 32'd0);
            step();
        end
        repeat (2) step();

        // reset with reads in flight
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        smp();
        chk("rmf_gnt", 32'(bus.if_gnt), 32'd1);
        step();
        rst_n = 1'b0;
        bus.if_addr = 32'h14;
        smp();
        chk("rmf_gnt0", 32'(bus.if_gnt), 32'd0);
        chk("rmf_en0", 32'(bus.mem_en), 32'd0);
        chk("rmf_busy0", 32'(bus.busy), 32'd0);
        chk("rmf_addr0", bus.mem_addr, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        idle();
        for (int c = 0; c < 6; c++) begin
            smp();
            chk("rmf_no_rv", 32'({bus.if_rvalid, bus.ls_rvalid}), 32'd0);
            step();
        end

        // single-byte write merges into existing word
        bus.ls_req   = 1'b1;
        bus.ls_we    = 4'h2;
        bus.ls_addr  = 32'h80;
        bus.ls_wdata = 32'h0000AB00;
        smp();
        chk("bw_gnt", 32'(bus.ls_gnt), 32'd1);
        chk("bw_we", 32'(bus.mem_we), 32'h2);
        step();
        bus.ls_we = 4'h0;
        step();
        smp();
        chk("bw_rd_gnt", 32'(bus.ls_gnt), 32'd1);
        step();
        idle();
        step();
        step();
        smp();
        chk("bw_rvalid", 32'(bus.ls_rvalid), 32'd1);
        chk("bw_rdata", bus.ls_rdata, 32'h1122AB44);
        repeat (3) step();

        // write granted in the cycle an IF read returns
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h104;
        step();
        idle();
        step();
        step();
        bus.ls_req   = 1'b1;
        bus.ls_we    = 4'hF;
        bus.ls_addr  = 32'h180;
        bus.ls_wdata = 32'h12345678;
        smp();
        chk("sim_ls_gnt", 32'(bus.ls_gnt), 32'd1);
        chk("sim_if_rv", 32'(bus.if_rvalid), 32'd1);
        chk("sim_if_rdata", bus.if_rdata, 32'h5A000104);
        step();
        idle();
        smp();
        chk("sim_gap_busy", 32'(bus.busy), 32'd1);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
